// File: rtl/var_state_loader_if.sv
// Bus between the bin-switch controller, the bin state memory, the var_cell
// array and the state loader.
interface var_state_loader_if #(
  parameter int NUM_VARS_A_BIN   = 8,
  parameter int WIDTH_VAR_STATES = 30,
  parameter int WIDTH_BIN        = 10,
  parameter int WIDTH_ADDR       = 13
);
  logic                                         start_load_i;
  logic                                         start_update_i;
  logic [WIDTH_BIN-1:0]                         bin_num_i;
  logic                                         busy_o;
  logic                                         done_load_o;
  logic                                         done_update_o;
  logic [WIDTH_BIN-1:0]                         cur_bin_num_o;
  logic                                         mem_rd_en_o;
  logic                                         mem_wr_en_o;
  logic [WIDTH_ADDR-1:0]                        mem_addr_o;
  logic [WIDTH_VAR_STATES-1:0]                  mem_wdata_o;
  logic [WIDTH_VAR_STATES-1:0]                  mem_rdata_i;
  logic [NUM_VARS_A_BIN-1:0]                    wr_states_o;
  logic [WIDTH_VAR_STATES-1:0]                  vars_states_o;
  logic [NUM_VARS_A_BIN*WIDTH_VAR_STATES-1:0]   vars_states_i;

  modport slave (
    input  start_load_i, start_update_i, bin_num_i, mem_rdata_i, vars_states_i,
    output busy_o, done_load_o, done_update_o, cur_bin_num_o,
           mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_wdata_o,
           wr_states_o, vars_states_o
  );

  modport master (
    output start_load_i, start_update_i, bin_num_i, mem_rdata_i, vars_states_i,
    input  busy_o, done_load_o, done_update_o, cur_bin_num_o,
           mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_wdata_o,
           wr_states_o, vars_states_o
  );
endinterface

// File: rtl/var_state_loader.sv
// Loads a bin's per-variable state words from memory into the var_cell array
// and writes snapshots of the var_cells back, optionally as one swap operation.
module var_state_loader #(
  parameter int NUM_VARS_A_BIN   = 8,
  parameter int WIDTH_VAR_STATES = 30,
  parameter int WIDTH_BIN        = 10,
  parameter int WIDTH_ADDR       = 13
) (
  input logic               clk,
  input logic               rst,
  var_state_loader_if.slave bus
);
  localparam int IDX_W = (NUM_VARS_A_BIN > 1) ? $clog2(NUM_VARS_A_BIN) : 1;
  localparam logic [IDX_W-1:0]          LAST_IDX = IDX_W'(NUM_VARS_A_BIN - 1);
  localparam logic [IDX_W-1:0]          ONE_IDX  = IDX_W'(1);
  localparam logic [NUM_VARS_A_BIN-1:0] CELL0    = NUM_VARS_A_BIN'(1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    UPD_SNAP = 3'd1,
    UPD_WR   = 3'd2,
    LD_RD    = 3'd3,
    LD_LAST  = 3'd4,
    DONE_UPD = 3'd5,
    DONE_LD  = 3'd6
  } state_t;

  state_t                       state_r;
  logic [IDX_W-1:0]             idx_r;
  logic [WIDTH_BIN-1:0]         ld_bin_r;
  logic [WIDTH_BIN-1:0]         cur_bin_r;
  logic                         pend_load_r;
  logic [WIDTH_VAR_STATES-1:0]  snap_r [NUM_VARS_A_BIN];
  logic                         busy_r;
  logic                         done_load_r;
  logic                         done_update_r;
  logic                         mem_rd_en_r;
  logic                         mem_wr_en_r;
  logic [WIDTH_ADDR-1:0]        mem_addr_r;
  logic [WIDTH_VAR_STATES-1:0]  mem_wdata_r;
  logic [NUM_VARS_A_BIN-1:0]    wr_states_r;
  logic [WIDTH_VAR_STATES-1:0]  vars_states_s;

  function automatic logic [WIDTH_ADDR-1:0] word_addr(
    input logic [WIDTH_BIN-1:0] bin,
    input logic [IDX_W-1:0]     idx
  );
    word_addr = WIDTH_ADDR'(bin) * WIDTH_ADDR'(NUM_VARS_A_BIN) + WIDTH_ADDR'(idx);
  endfunction

  // Sequencer: all strobes are registered one cycle ahead of the state they belong to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= IDLE;
      idx_r         <= '0;
      ld_bin_r      <= '0;
      cur_bin_r     <= '0;
      pend_load_r   <= 1'b0;
      busy_r        <= 1'b0;
      done_load_r   <= 1'b0;
      done_update_r <= 1'b0;
      mem_rd_en_r   <= 1'b0;
      mem_wr_en_r   <= 1'b0;
      mem_addr_r    <= '0;
      mem_wdata_r   <= '0;
      wr_states_r   <= '0;
      for (int k = 0; k < NUM_VARS_A_BIN; k++) begin
        snap_r[k] <= '0;
      end
    end else begin
      done_load_r   <= 1'b0;
      done_update_r <= 1'b0;
      mem_rd_en_r   <= 1'b0;
      mem_wr_en_r   <= 1'b0;
      mem_addr_r    <= '0;
      mem_wdata_r   <= '0;
      wr_states_r   <= '0;

      case (state_r)
        IDLE: begin
          if (bus.start_update_i) begin
            // Snapshot on acceptance so cell activity after the request cannot leak in.
            for (int k = 0; k < NUM_VARS_A_BIN; k++) begin
              snap_r[k] <= bus.vars_states_i[k*WIDTH_VAR_STATES +: WIDTH_VAR_STATES];
            end
            state_r     <= UPD_SNAP;
            busy_r      <= 1'b1;
            idx_r       <= '0;
            pend_load_r <= bus.start_load_i;
            if (bus.start_load_i) begin
              ld_bin_r <= bus.bin_num_i;
            end else begin
              ld_bin_r <= ld_bin_r;
            end
          end else if (bus.start_load_i) begin
            state_r     <= LD_RD;
            busy_r      <= 1'b1;
            idx_r       <= '0;
            ld_bin_r    <= bus.bin_num_i;
            mem_rd_en_r <= 1'b1;
            mem_addr_r  <= word_addr(bus.bin_num_i, '0);
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end

        UPD_SNAP: begin
          state_r     <= UPD_WR;
          idx_r       <= '0;
          mem_wr_en_r <= 1'b1;
          mem_addr_r  <= word_addr(cur_bin_r, '0);
          mem_wdata_r <= snap_r[0];
        end

        UPD_WR: begin
          if (idx_r == LAST_IDX) begin
            state_r       <= DONE_UPD;
            done_update_r <= 1'b1;
          end else begin
            idx_r       <= idx_r + ONE_IDX;
            mem_wr_en_r <= 1'b1;
            mem_addr_r  <= word_addr(cur_bin_r, idx_r + ONE_IDX);
            mem_wdata_r <= snap_r[idx_r + ONE_IDX];
          end
        end

        DONE_UPD: begin
          if (pend_load_r) begin
            pend_load_r <= 1'b0;
            state_r     <= LD_RD;
            idx_r       <= '0;
            mem_rd_en_r <= 1'b1;
            mem_addr_r  <= word_addr(ld_bin_r, '0);
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end

        LD_RD: begin
          // The word read this cycle lands in cell idx on the next cycle.
          wr_states_r <= CELL0 << idx_r;
          if (idx_r == LAST_IDX) begin
            state_r <= LD_LAST;
          end else begin
            idx_r       <= idx_r + ONE_IDX;
            mem_rd_en_r <= 1'b1;
            mem_addr_r  <= word_addr(ld_bin_r, idx_r + ONE_IDX);
          end
        end

        LD_LAST: begin
          state_r     <= DONE_LD;
          cur_bin_r   <= ld_bin_r;
          done_load_r <= 1'b1;
        end

        DONE_LD: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          idx_r   <= '0;
        end

        default: begin
          state_r     <= IDLE;
          busy_r      <= 1'b0;
          pend_load_r <= 1'b0;
          idx_r       <= '0;
        end
      endcase
    end
  end

  // Read data arrives one cycle after its strobe, aligned with the cell write strobe.
  always_comb begin
    vars_states_s = '0;
    if (|wr_states_r) begin
      vars_states_s = bus.mem_rdata_i;
    end else begin
      vars_states_s = '0;
    end
  end

  assign bus.busy_o        = busy_r;
  assign bus.done_load_o   = done_load_r;
  assign bus.done_update_o = done_update_r;
  assign bus.cur_bin_num_o = cur_bin_r;
  assign bus.mem_rd_en_o   = mem_rd_en_r;
  assign bus.mem_wr_en_o   = mem_wr_en_r;
  assign bus.mem_addr_o    = mem_addr_r;
  assign bus.mem_wdata_o   = mem_wdata_r;
  assign bus.wr_states_o   = wr_states_r;
  assign bus.vars_states_o = vars_states_s;

endmodule
